// File: rtl/digit_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
// Optional feature macro used by the top: SUB_SIGNED_OVF_EN.
package sub_pkg;
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_DIGIT = 2;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter is kept at least one bit wide so a single-digit build still elaborates.
    function automatic int cnt_bits(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/digit_serial_subtractor_if.sv
// Operand/result handshake bundle for the digit-serial subtractor.
interface digit_serial_subtractor_if import sub_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out, overflow
    );

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out, overflow
    );
endinterface

// File: rtl/digit_serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/digit_serial_subtractor.sv
// Digit-serial ripple-borrow subtractor: a - b - b_in, DIGIT bits per clock.
// Define SUB_SIGNED_OVF_EN to build the signed-overflow flag; otherwise overflow reads 0.
module digit_serial_subtractor import sub_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input logic                     clk,
    input logic                     rst_n,
    digit_serial_subtractor_if.slave bus
);
    localparam int             N    = num_digits(WIDTH, DIGIT);
    localparam int             CW   = cnt_bits(WIDTH, DIGIT);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] a_dig, b_dig, d_dig;
    logic [DIGIT:0]   chain;
    logic             last_dig;

    assign a_dig    = a_q[int'(cnt_q)*DIGIT +: DIGIT];
    assign b_dig    = b_q[int'(cnt_q)*DIGIT +: DIGIT];
    assign last_dig = (cnt_q == LAST);
    assign chain[0] = borrow_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_subtractor u_fs (
            .a    (a_dig[i]),
            .b    (b_dig[i]),
            .bin  (chain[i]),
            .d    (d_dig[i]),
            .bout (chain[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    borrow_d = bus.b_in;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // After the last digit borrow_q holds the unsigned borrow out.
                diff_d[int'(cnt_q)*DIGIT +: DIGIT] = d_dig;
                borrow_d = chain[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (last_dig) state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.b_out     = borrow_q;

`ifdef SUB_SIGNED_OVF_EN
    logic ovf_q;

    // Sampled on the final digit, when d_dig carries the result MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_dig) begin
            ovf_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_dig[DIGIT-1] ^ a_q[WIDTH-1]);
        end
    end

    assign bus.overflow = ovf_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Scoreboard bench for digit_serial_subtractor (WIDTH=10, DIGIT=2).
module tb_digit_serial_subtractor;
`ifdef SUB_SIGNED_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [9:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    digit_serial_subtractor_if #(.WIDTH(10)) bus ();

    digit_serial_subtractor #(.WIDTH(10), .DIGIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every completed output handshake against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got diff 0x%0h, expected no output", bus.diff);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("diff", 32'(bus.diff), 32'(e.diff));
                check("b_out", 32'(bus.b_out), 32'(e.bout));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [9:0] a, input logic [9:0] b, input logic bin,
                         input logic [9:0] ed, input logic eb, input logic eo, input int hold);
        exp_t e;
        int   lat;
        wait_ready();
        bus.a        = a;
        bus.b        = b;
        bus.b_in     = bin;
        bus.in_valid = 1'b1;
        e.diff = ed;
        e.bout = eb;
        e.ovf  = eo & OVF_ON;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a        = 10'($urandom);
        bus.b        = 10'($urandom);
        bus.b_in     = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 10'h3C0 + 10'(i);
            bus.b        = 10'h011;
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_diff_stable", 32'(bus.diff), 32'(ed));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("out_valid_after_hs", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.b_in      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_b_out", 32'(bus.b_out), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(10'd100,  10'd37,  1'b0, 10'd63,  1'b0, 1'b0, 0);
        do_op(10'd0,    10'd1,   1'b0, 10'h3FF, 1'b1, 1'b0, 0);
        do_op(10'h1FF,  10'h3FF, 1'b0, 10'h200, 1'b1, 1'b1, 0);
        do_op(10'd5,    10'd5,   1'b1, 10'h3FF, 1'b1, 1'b0, 0);
        do_op(10'h200,  10'h001, 1'b0, 10'h1FF, 1'b0, 1'b1, 0);
        do_op(10'h2AB,  10'h155, 1'b1, 10'h155, 1'b0, 1'b1, 3);

        // Reset during the second RUN cycle; this operation never completes.
        wait_ready();
        bus.a        = 10'h155;
        bus.b        = 10'h0AA;
        bus.b_in     = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_b_out", 32'(bus.b_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("postrst_out_valid", 32'(bus.out_valid), 32'd0);

        do_op(10'd200, 10'd199, 1'b0, 10'd1, 1'b0, 1'b0, 0);

        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
